// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter needs at least one bit even when WIDTH is 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in.
`default_nettype none

module full_subtractor (
  input  logic input_a,
  input  logic input_b,
  input  logic input_borrow,
  output logic output_diff,
  output logic output_borrow
);

  assign output_diff   = input_a ^ input_b ^ input_borrow;
  assign output_borrow = (~input_a & input_b) | (~(input_a ^ input_b) & input_borrow);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             input_clk,
  input  logic             input_rst_n,
  input  logic             input_start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_borrow,
  output logic             output_busy,
  output logic             output_done,
  output logic [WIDTH-1:0] output_diff,
  output logic             output_borrow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [CW-1:0]    cnt;
  logic             borrow_q;
  logic             borrow_res;
  logic             cell_diff;
  logic             cell_borrow;

  full_subtractor u_cell (
    .input_a       (a_sr[0]),
    .input_b       (b_sr[0]),
    .input_borrow  (borrow_q),
    .output_diff   (cell_diff),
    .output_borrow (cell_borrow)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (input_start) state_nx = RUN;
      RUN:     if (cnt == LAST_BIT) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) state <= IDLE;
    else              state <= state_nx;
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      cnt        <= '0;
      borrow_q   <= 1'b0;
      borrow_res <= 1'b0;
    end else if (state == IDLE && input_start) begin
      a_sr     <= input_a;
      b_sr     <= input_b;
      borrow_q <= input_borrow;
      cnt      <= '0;
    end else if (state == RUN) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      // New bit enters at the MSB; the form also holds for WIDTH == 1.
      diff_sr  <= WIDTH'({cell_diff, diff_sr} >> 1);
      borrow_q <= cell_borrow;
      cnt      <= cnt + CW'(1);
      if (cnt == LAST_BIT) borrow_res <= cell_borrow;
    end
  end

  assign output_busy   = (state != IDLE);
  assign output_done   = (state == DONE);
  assign output_diff   = diff_sr;
  assign output_borrow = borrow_res;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
`default_nettype none

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;
  logic       s1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       busy1, done1, bo1;
  logic [0:0] diff1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .input_clk(clk), .input_rst_n(rst_n), .input_start(s8),
    .input_a(a8), .input_b(b8), .input_borrow(bin8),
    .output_busy(busy8), .output_done(done8),
    .output_diff(diff8), .output_borrow(bo8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .input_clk(clk), .input_rst_n(rst_n), .input_start(s1),
    .input_a(a1), .input_b(b1), .input_borrow(bin1),
    .output_busy(busy1), .output_done(done1),
    .output_diff(diff1), .output_borrow(bo1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 8-bit operation; optional start pulses with other operands during RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input bit noise);
    int busy_n, done_n, done_at;
    logic [7:0] got_d;
    logic got_b;
    busy_n = 0; done_n = 0; done_at = -1; got_d = '0; got_b = 1'b0;
    s8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    tick();
    s8 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (busy8) busy_n++;
      if (noise && (k == 3 || k == 8)) begin
        s8 = 1'b1; a8 = ~a; b8 = 8'h11; bin8 = ~bin;
      end else begin
        s8 = 1'b0;
      end
      tick();
      if (done8) begin
        done_n++; done_at = k; got_d = diff8; got_b = bo8;
      end
    end
    s8 = 1'b0;
    check("diff_at_done", 32'(got_d), 32'(ed));
    check("borrow_at_done", 32'(got_b), 32'(eb));
    check("done_pulses", 32'(done_n), 32'd1);
    check("done_edge", 32'(done_at), 32'd8);
    check("busy_cycles", 32'(busy_n), 32'd9);
    check("idle_busy", 32'(busy8), 32'd0);
    check("diff_held", 32'(diff8), 32'(ed));
    check("borrow_held", 32'(bo8), 32'(eb));
  endtask

  task automatic op1(input logic a, input logic b, input logic bin,
                     input logic ed, input logic eb);
    s1 = 1'b1; a1 = a; b1 = b; bin1 = bin;
    tick();
    s1 = 1'b0;
    check("w1_done_early", 32'(done1), 32'd0);
    tick();
    check("w1_done", 32'(done1), 32'd1);
    check("w1_diff", 32'(diff1), 32'(ed));
    check("w1_borrow", 32'(bo1), 32'(eb));
    tick();
    check("w1_idle", 32'(busy1), 32'd0);
  endtask

  // Truth table index {a,b,bin}: diff and borrow, hand-derived.
  logic [7:0] tt_diff   = 8'b1001_0110;
  logic [7:0] tt_borrow = 8'b1000_1110;

  initial begin
    repeat (3) tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(bo8), 32'd0);
    rst_n = 1'b1;
    tick();

    op8(8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0);
    op8(8'd5,   8'd10,  1'b0, 8'd251, 1'b1, 1'b0);
    op8(8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0);
    op8(8'd255, 8'd0,   1'b0, 8'd255, 1'b0, 1'b0);
    op8(8'd128, 8'd128, 1'b0, 8'd0,   1'b0, 1'b0);
    op8(8'd200, 8'd55,  1'b1, 8'd144, 1'b0, 1'b1);
    op8(8'd1,   8'd1,   1'b1, 8'd255, 1'b1, 1'b0);
    op8(8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b1);

    // Abort mid-RUN with reset.
    s8 = 1'b1; a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0;
    tick();
    s8 = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_borrow", 32'(bo8), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_done", 32'(done8), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    op8(8'd50, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0], tt_diff[i], tt_borrow[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
